// File: rtl/dev_bus_arbiter.sv
// Two-master device-bus arbiter: latches the winning request, drives one bridge access, returns registered read data.
// Build option: define DEV_ARB_FIXED_PRIO_EN for fixed priority (M0 wins contention); default is round-robin.
module dev_bus_arbiter #(
    parameter logic [31:0] DEV0_BASE = 32'h7f00,
    parameter logic [31:0] DEV1_BASE = 32'h7f10,
    parameter int unsigned DEV_SPAN  = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wd,
    input  logic [31:0] m1_wd,
    input  logic        m0_we,
    input  logic        m1_we,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] PrAddr,
    output logic [31:0] PrWD,
    output logic        PrWE,
    input  logic [31:0] PrRD
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [31:0] SPAN_M1   = 32'(DEV_SPAN) - 32'd1;
    localparam logic [31:0] DEV0_LAST = DEV0_BASE + SPAN_M1;
    localparam logic [31:0] DEV1_LAST = DEV1_BASE + SPAN_M1;

    logic [1:0]  state_q, state_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [31:0] cur_wd_q, cur_wd_d;
    logic        cur_we_q, cur_we_d;
    logic        cur_id_q, cur_id_d;
    logic        last_q, last_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic hit;
    logic in_access;
    logic in_resp;
    logic pick_m1;

    assign hit = ((cur_addr_q >= DEV0_BASE) && (cur_addr_q <= DEV0_LAST)) ||
                 ((cur_addr_q >= DEV1_BASE) && (cur_addr_q <= DEV1_LAST));

    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);

`ifdef DEV_ARB_FIXED_PRIO_EN
    assign pick_m1 = m1_req & ~m0_req;
`else
    // Under contention the master that did not win last time takes the bus.
    assign pick_m1 = m1_req & (~m0_req | ~last_q);
`endif

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        cur_wd_d   = cur_wd_q;
        cur_we_d   = cur_we_q;
        cur_id_d   = cur_id_q;
        last_d     = last_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            ST_ACCESS: begin
                rdata_d = (cur_we_q | ~hit) ? 32'd0 : PrRD;
                err_d   = ~hit;
                state_d = ST_RESP;
            end
            default: begin
                if (m0_req | m1_req) begin
                    cur_id_d   = pick_m1;
                    cur_addr_d = pick_m1 ? m1_addr : m0_addr;
                    cur_wd_d   = pick_m1 ? m1_wd   : m0_wd;
                    cur_we_d   = pick_m1 ? m1_we   : m0_we;
                    last_d     = pick_m1;
                    state_d    = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            cur_wd_q   <= '0;
            cur_we_q   <= 1'b0;
            cur_id_q   <= 1'b0;
            last_q     <= 1'b1;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            cur_wd_q   <= cur_wd_d;
            cur_we_q   <= cur_we_d;
            cur_id_q   <= cur_id_d;
            last_q     <= last_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign m0_gnt    = in_access & ~cur_id_q;
    assign m1_gnt    = in_access &  cur_id_q;
    assign PrAddr    = in_access ? cur_addr_q : 32'd0;
    assign PrWD      = in_access ? cur_wd_q   : 32'd0;
    assign PrWE      = in_access & cur_we_q & hit;

    assign m0_rvalid = in_resp & ~cur_id_q;
    assign m1_rvalid = in_resp &  cur_id_q;
    assign rdata     = in_resp ? rdata_q : 32'd0;
    assign err       = in_resp & err_q;

endmodule

// File: doc/dev_bus_arbiter.md
# dev_bus_arbiter

Arbitrates the device bus between two masters: M0, the CPU data port, and M1, a secondary master such as debug or DMA. Only one access reaches the device bridge at a time. The block latches the winning request, drives one bridge access, and returns registered read data with a valid strobe. It also flags accesses that decode to neither device window. It sits between the masters and the bridge's `PrAddr`/`PrWD`/`PrWE`/`PrRD` port.

## Interface
Parameters:
- `DEV0_BASE`, default `32'h7f00`: Dev0 window base.
- `DEV1_BASE`, default `32'h7f10`: Dev1 window base.
- `DEV_SPAN`, default `12`: window size in bytes; a window hits for `base <= addr <= base+DEV_SPAN-1`.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `m0_req`, `m1_req` input 1 each: access request; held until the matching `gnt`.
- `m0_addr`, `m1_addr` input 32 each: byte address.
- `m0_wd`, `m1_wd` input 32 each: write data.
- `m0_we`, `m1_we` input 1 each: 1 = write, 0 = read.
- `m0_gnt`, `m1_gnt` output 1 each: one-cycle grant pulse.
- `m0_rvalid`, `m1_rvalid` output 1 each: one-cycle response strobe.
- `rdata` output 32: response read data; shared, qualified by `mX_rvalid`.
- `err` output 1: decode error, valid with `rvalid`.
- `PrAddr` output 32, `PrWD` output 32, `PrWE` output 1: to the bridge.
- `PrRD` input 32: from the bridge, combinational in the same cycle.

## Operation
- States: IDLE, ACCESS, RESP.
- Arbitration happens in IDLE and RESP.
  - If any `req` is high, pick a winner and latch its addr/wd/we and id into `cur_*`. Next state is ACCESS.
  - If no `req` is high, next state is IDLE.
- ACCESS:
  - `PrAddr=cur_addr`, `PrWD=cur_wd`.
  - `PrWE = cur_we & hit`, where `hit` = address falls in the Dev0 or Dev1 window.
  - `gnt` of `cur_id` is high for this cycle.
  - End of cycle: capture `rdata_q <= (cur_we | ~hit) ? 0 : PrRD` and `err_q <= ~hit`. Next state is RESP.
- RESP:
  - `rvalid` of `cur_id` is high; `rdata=rdata_q`, `err=err_q`.
  - Arbitration runs in the same cycle, so back-to-back accesses are possible.
- Default arbitration is round-robin.
  - A `last` register holds the id of the most recent grant.
  - When both masters request, the master ≠ `last` wins. A single requester always wins.
  - `last` updates on entry to ACCESS.
- Masters must keep `req`/addr/wd/we stable until `gnt`. `req` sampled in RESP for the master being granted in that ACCESS is ignored, because that request is already consumed.
- A decode-error write asserts no `PrWE`, returns `rdata=0`, `err=1`.
- Outside ACCESS: `PrAddr=0`, `PrWD=0`, `PrWE=0`.

## Timing
- Reset values:
  - state = IDLE; `last` = 1, so M0 wins the first tie.
  - All `gnt`/`rvalid`/`err` = 0; `rdata` = 0; all `Pr*` = 0.
- Latency: `req` seen at edge N → ACCESS (`gnt`, bus drive) in cycle N+1 → `rvalid` in cycle N+2.
- Throughput: one access per 2 cycles when requests are continuous. Alternating masters under contention: M0, M1, M0, …
- Simultaneous `m0_req` and `m1_req` on the same edge are resolved by `last`. The loser's request is held and granted in the next RESP-cycle arbitration.
- `reset` in ACCESS: the write is still driven in that cycle (combinational). At the edge the state returns to IDLE, no `rvalid` is produced, and `last` = 1.
- `reset` in RESP: the pending `rvalid` is dropped from the next cycle.
- `PrRD` is sampled only at the end of ACCESS. Device reads are side-effect free; `PrWE` is never asserted outside ACCESS.

## Configuration
- `DEV_ARB_FIXED_PRIO_EN` defined: fixed priority.
  - M0 always wins contention; `last` is still kept but not used for selection.
  - M1 can starve under continuous M0 requests.
- `DEV_ARB_FIXED_PRIO_EN` undefined: round-robin as described in Operation.

## Test plan
- Single M0 write `addr=32'h7f04`, `wd=32'h0000_00AB` → `m0_gnt` at N+1 with `PrAddr=32'h7f04`, `PrWE=1`, `PrWD=32'hAB`; `m0_rvalid` at N+2, `err=0`, `rdata=0`.
- M1 read `32'h7f14` with bench `PrRD=32'h1234_5678` during ACCESS → `m1_rvalid` at N+2, `rdata=32'h1234_5678`, `PrWE` never 1.
- Both masters request continuously from reset for 4 grants → grant order M0, M1, M0, M1, with grants 2 cycles apart. With `DEV_ARB_FIXED_PRIO_EN` → M0, M0, M0, M0.
- M0 write to `32'h7f0c` (outside both windows) → `PrWE=0` throughout; `m0_rvalid` with `err=1`, `rdata=0`.
- Boundary addresses `32'h7f0b`, `32'h7f10`, `32'h7f1b` → `err=0`. Addresses `32'h7eff`, `32'h7f1c` → `err=1`.
- `reset` asserted in the ACCESS cycle of an M1 read → no `m1_rvalid` follows. Next cycle all outputs are 0 and state is IDLE. A fresh tie then grants M0 first.
